branch_predict_resolve_unit: RTL and testbench

//  Successor to the combinational jump/branch next-PC unit. Adds a direct-mapped branch target

---
 rtl/branch_predict_resolve_unit.sv | 152 +++++++++++++++
 tb/tb_branch_predict_resolve_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve_unit.sv
// Branch predictor and resolver: a direct-mapped BTB with saturating direction counters is
// looked up from IF, control flow is resolved in EX, and a registered one-cycle redirect is issued.
module branch_predict_resolve_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   IfPC,
  output logic              PredTaken,
  output logic [31:0]       PredTarget,
  input  logic              ExValid,
  input  logic [PC_W-1:0]   ExPC,
  input  logic              ExBranch,
  input  logic              ExJump,
  input  logic [1:0]        ExJumpType,
  input  logic [31:0]       ExImm,
  input  logic [31:0]       ExRegBase,
  input  logic [31:0]       ExALUFlag,
  input  logic              ExPredTaken,
  input  logic [31:0]       ExPredTarget,
  output logic [31:0]       ExPCPlus4,
  output logic              Redirect,
  output logic [31:0]       RedirectPC,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] MispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};

  logic             btb_valid   [ENTRIES];
  logic [TAG_W-1:0] btb_tag     [ENTRIES];
  logic [PC_W-1:0]  btb_target  [ENTRIES];
  logic [CNT_W-1:0] btb_cnt     [ENTRIES];
  logic             btb_is_jump [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [31:0]      ex_pc_ext;
  logic             is_jal;
  logic             is_jalr;
  logic             act_taken;
  logic [31:0]      act_target;
  logic             ctrl_valid;
  logic             ctrl_mispredict;
  logic             alias_mispredict;
  logic             mispredict;
  logic [31:0]      redirect_target;
  logic             unused_flag_bits;

  assign unused_flag_bits = ^ExALUFlag[31:1];

  // Fetch-side lookup sees only pre-edge BTB contents.
  always_comb begin
    if_idx     = IfPC[IDX_W+1:2];
    if_tag     = IfPC[PC_W-1:IDX_W+2];
    if_hit     = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    PredTaken  = if_hit && (btb_is_jump[if_idx] || btb_cnt[if_idx][CNT_W-1]);
    PredTarget = PredTaken ? 32'(btb_target[if_idx]) : 32'(IfPC) + 32'd4;
  end

  always_comb begin
    ex_idx    = ExPC[IDX_W+1:2];
    ex_tag    = ExPC[PC_W-1:IDX_W+2];
    ex_hit    = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    ex_pc_ext = 32'(ExPC);
    ExPCPlus4 = ex_pc_ext + 32'd4;
    is_jal    = (ExJumpType == 2'b01);
    is_jalr   = (ExJumpType == 2'b10);
    act_taken = is_jal || is_jalr || (ExBranch && ExALUFlag[0]);

    if (is_jal)
      act_target = ex_pc_ext + ExImm;
    else if (is_jalr)
      act_target = (ExRegBase + ExImm) & 32'hFFFF_FFFE;
    else if (ExBranch && ExALUFlag[0])
      act_target = ex_pc_ext + ExImm;
    else
      act_target = ExPCPlus4;

    ctrl_valid      = ExValid && (ExBranch || ExJump);
    ctrl_mispredict = ctrl_valid && ((act_taken != ExPredTaken) ||
                                     (act_taken && (act_target != ExPredTarget)));
    // A taken prediction on a non-control instruction came from an aliased stale entry.
    alias_mispredict = ExValid && !ExBranch && !ExJump && ExPredTaken;
    mispredict       = ctrl_mispredict || alias_mispredict;
    redirect_target  = alias_mispredict ? ExPCPlus4 : act_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Redirect     <= 1'b0;
      RedirectPC   <= 32'd0;
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      Redirect <= mispredict;
      if (mispredict)
        RedirectPC <= redirect_target;
      if (ctrl_valid && (BranchCount != '1))
        BranchCount <= BranchCount + STAT_W'(1);
      if (mispredict && (MispredCount != '1))
        MispredCount <= MispredCount + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]   <= 1'b0;
        btb_tag[i]     <= '0;
        btb_target[i]  <= '0;
        btb_cnt[i]     <= '0;
        btb_is_jump[i] <= 1'b0;
      end
    end else if (ctrl_valid) begin
      if (ex_hit) begin
        if (ExJump) begin
          btb_target[ex_idx]  <= act_target[PC_W-1:0];
          btb_is_jump[ex_idx] <= 1'b1;
        end else begin
          if (act_taken) begin
            btb_target[ex_idx] <= act_target[PC_W-1:0];
            if (btb_cnt[ex_idx] != CNT_MAX)
              btb_cnt[ex_idx] <= btb_cnt[ex_idx] + CNT_W'(1);
          end else if (btb_cnt[ex_idx] != '0) begin
            btb_cnt[ex_idx] <= btb_cnt[ex_idx] - CNT_W'(1);
          end
        end
      end else if (act_taken) begin
        btb_valid[ex_idx]   <= 1'b1;
        btb_tag[ex_idx]     <= ex_tag;
        btb_target[ex_idx]  <= act_target[PC_W-1:0];
        btb_cnt[ex_idx]     <= CNT_WEAK;
        btb_is_jump[ex_idx] <= ExJump;
      end
    end else if (alias_mispredict && ex_hit) begin
      btb_valid[ex_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Self-checking bench: a spec-level BTB/resolve model compared every cycle, plus directed literal checks.
module tb_branch_predict_resolve_unit;

  localparam int PC_W = 9;
  localparam int ENTRIES = 16;
  localparam int STAT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  IfPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        ExValid;
  logic [8:0]  ExPC;
  logic        ExBranch;
  logic        ExJump;
  logic [1:0]  ExJumpType;
  logic [31:0] ExImm;
  logic [31:0] ExRegBase;
  logic [31:0] ExALUFlag;
  logic        ExPredTaken;
  logic [31:0] ExPredTarget;
  logic [31:0] ExPCPlus4;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [3:0]  BranchCount;
  logic [3:0]  MispredCount;

  int checks = 0;
  int failures = 0;

  branch_predict_resolve_unit #(.PC_W(9), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
    .clk(clk), .reset(reset), .IfPC(IfPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ExValid(ExValid), .ExPC(ExPC), .ExBranch(ExBranch), .ExJump(ExJump),
    .ExJumpType(ExJumpType), .ExImm(ExImm), .ExRegBase(ExRegBase), .ExALUFlag(ExALUFlag),
    .ExPredTaken(ExPredTaken), .ExPredTarget(ExPredTarget), .ExPCPlus4(ExPCPlus4),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .BranchCount(BranchCount),
    .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  // Reference model state: the BTB as plain arrays indexed by (pc/4) mod ENTRIES, tag = pc/64.
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  int          m_cnt    [ENTRIES];
  bit          m_isjump [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_redirect;
  logic [31:0] m_redirect_pc;
  int          m_bcount;
  int          m_mcount;
  bit          started = 0;

  int          r_idx;
  int          r_tag;
  bit          r_hit;
  bit          r_taken;
  bit          r_ctrl;
  bit          r_mis;
  bit          r_alias;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = 0; m_isjump[i] = 0; m_target[i] = 0;
      end
      m_redirect = 0; m_redirect_pc = 0; m_bcount = 0; m_mcount = 0;
    end else begin
      r_pc  = 32'(ExPC);
      r_idx = (int'(ExPC) / 4) % ENTRIES;
      r_tag = int'(ExPC) / 64;
      r_hit = m_valid[r_idx] && (m_tag[r_idx] == r_tag);
      r_taken = (ExJumpType == 2'd1) || (ExJumpType == 2'd2) || (ExBranch && ExALUFlag[0]);
      case (1'b1)
        (ExJumpType == 2'd1):       r_tgt = r_pc + ExImm;
        (ExJumpType == 2'd2):       r_tgt = (ExRegBase + ExImm) & ~32'd1;
        (ExBranch && ExALUFlag[0]): r_tgt = r_pc + ExImm;
        default:                    r_tgt = r_pc + 4;
      endcase
      r_ctrl  = ExValid && (ExBranch || ExJump);
      r_mis   = r_ctrl && ((r_taken != ExPredTaken) || (r_taken && r_tgt != ExPredTarget));
      r_alias = ExValid && !ExBranch && !ExJump && ExPredTaken;
      m_redirect = r_mis || r_alias;
      if (m_redirect) m_redirect_pc = r_alias ? r_pc + 4 : r_tgt;
      if (r_ctrl && m_bcount < STAT_MAX) m_bcount++;
      if (m_redirect && m_mcount < STAT_MAX) m_mcount++;
      if (r_ctrl) begin
        if (r_hit && ExJump) begin
          m_target[r_idx] = r_tgt % 512; m_isjump[r_idx] = 1;
        end else if (r_hit) begin
          if (r_taken) begin
            m_target[r_idx] = r_tgt % 512;
            m_cnt[r_idx] = (m_cnt[r_idx] + 1 > 3) ? 3 : m_cnt[r_idx] + 1;
          end else begin
            m_cnt[r_idx] = (m_cnt[r_idx] - 1 < 0) ? 0 : m_cnt[r_idx] - 1;
          end
        end else if (r_taken) begin
          m_valid[r_idx] = 1; m_tag[r_idx] = r_tag; m_target[r_idx] = r_tgt % 512;
          m_cnt[r_idx] = 2; m_isjump[r_idx] = ExJump;
        end
      end else if (r_alias && r_hit) begin
        m_valid[r_idx] = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Single compare process on the falling edge, away from the state-update edge.
  always @(negedge clk) begin
    if (started) begin
      automatic int  idx = (int'(IfPC) / 4) % ENTRIES;
      automatic bit  hit = m_valid[idx] && (m_tag[idx] == int'(IfPC) / 64);
      automatic bit  tkn = hit && (m_isjump[idx] || m_cnt[idx] >= 2);
      automatic logic [31:0] tgt = tkn ? m_target[idx] : 32'(IfPC) + 32'd4;
      checkOutput("model_pred_taken", 32'(PredTaken), 32'(tkn));
      checkOutput("model_pred_target", PredTarget, tgt);
      checkOutput("model_ex_pc_plus4", ExPCPlus4, 32'(ExPC) + 32'd4);
      checkOutput("model_redirect", 32'(Redirect), 32'(m_redirect));
      if (m_redirect) checkOutput("model_redirect_pc", RedirectPC, m_redirect_pc);
      checkOutput("model_branch_count", 32'(BranchCount), 32'(m_bcount));
      checkOutput("model_mispred_count", 32'(MispredCount), 32'(m_mcount));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [8:0] pc, input bit br, input bit jmp,
                               input logic [1:0] jt, input logic [31:0] imm,
                               input logic [31:0] base, input logic [31:0] flag,
                               input bit pt, input logic [31:0] ptgt);
    ExValid = v; ExPC = pc; ExBranch = br; ExJump = jmp; ExJumpType = jt; ExImm = imm;
    ExRegBase = base; ExALUFlag = flag; ExPredTaken = pt; ExPredTarget = ptgt;
  endtask

  task automatic idle();
    applyStimulus(0, 9'h0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1; IfPC = 9'h0; idle();
    tick(); tick();
    reset = 0;

    // Reset state and empty-BTB prediction
    IfPC = 9'h040; idle(); #2;
    checkOutput("reset_pred_taken", 32'(PredTaken), 32'd0);
    checkOutput("reset_pred_target", PredTarget, 32'h44);
    checkOutput("reset_redirect", 32'(Redirect), 32'd0);
    checkOutput("reset_redirect_pc", RedirectPC, 32'd0);
    checkOutput("reset_branch_count", 32'(BranchCount), 32'd0);
    checkOutput("reset_mispred_count", 32'(MispredCount), 32'd0);
    tick();

    // JAL at 0x040 predicted not taken
    applyStimulus(1, 9'h040, 0, 1, 2'b01, 32'h20, 0, 0, 0, 0); #2;
    checkOutput("jal_same_cycle_old", 32'(PredTaken), 32'd0);
    tick();
    idle(); #2;
    checkOutput("jal_redirect", 32'(Redirect), 32'd1);
    checkOutput("jal_redirect_pc", RedirectPC, 32'h60);
    checkOutput("jal_mispred_count", 32'(MispredCount), 32'd1);
    checkOutput("jal_pred_taken", 32'(PredTaken), 32'd1);
    checkOutput("jal_pred_target", PredTarget, 32'h60);
    tick();
    checkOutput("jal_redirect_drop", 32'(Redirect), 32'd0);

    // Branch at 0x080, imm -8: taken x3, then not taken x2
    IfPC = 9'h080;
    applyStimulus(1, 9'h080, 1, 0, 2'b00, 32'hFFFF_FFF8, 0, 1, 0, 0); tick();
    idle(); #2;
    checkOutput("br_alloc_taken", 32'(PredTaken), 32'd1);
    checkOutput("br_alloc_target", PredTarget, 32'h78);
    checkOutput("br_alloc_redirect_pc", RedirectPC, 32'h78);
    applyStimulus(1, 9'h080, 1, 0, 2'b00, 32'hFFFF_FFF8, 0, 1, 1, 32'h78); tick();
    applyStimulus(1, 9'h080, 1, 0, 2'b00, 32'hFFFF_FFF8, 0, 1, 1, 32'h78); tick();
    applyStimulus(1, 9'h080, 1, 0, 2'b00, 32'hFFFF_FFF8, 0, 0, 1, 32'h78); tick();
    #2;
    checkOutput("br_nt1_still_taken", 32'(PredTaken), 32'd1);
    checkOutput("br_nt1_redirect_pc", RedirectPC, 32'h84);
    applyStimulus(1, 9'h080, 1, 0, 2'b00, 32'hFFFF_FFF8, 0, 0, 1, 32'h78); tick();
    idle(); #2;
    checkOutput("br_nt2_back_to_back", 32'(Redirect), 32'd1);
    checkOutput("br_nt2_pred_taken", 32'(PredTaken), 32'd0);
    checkOutput("br_nt2_pred_target", PredTarget, 32'h84);
    checkOutput("br_branch_count", 32'(BranchCount), 32'd6);
    checkOutput("br_mispred_count", 32'(MispredCount), 32'd4);
    tick();

    // JALR at 0x0C0: mispredicted, then correctly predicted
    IfPC = 9'h0C0;
    applyStimulus(1, 9'h0C0, 0, 1, 2'b10, 32'h10, 32'h101, 0, 0, 0); tick();
    idle(); #2;
    checkOutput("jalr_redirect", 32'(Redirect), 32'd1);
    checkOutput("jalr_redirect_pc", RedirectPC, 32'h110);
    applyStimulus(1, 9'h0C0, 0, 1, 2'b10, 32'h10, 32'h0F0, 0, 1, 32'h100); tick();
    idle(); #2;
    checkOutput("jalr_no_redirect", 32'(Redirect), 32'd0);
    checkOutput("jalr_pred_target", PredTarget, 32'h100);
    tick();

    // Aliasing: 0x040 and 0x140 share an index
    IfPC = 9'h040;
    applyStimulus(1, 9'h040, 0, 1, 2'b01, 32'h20, 0, 0, 0, 0); #2;
    checkOutput("alias_same_cycle_miss", 32'(PredTaken), 32'd0);
    tick();
    applyStimulus(1, 9'h140, 0, 1, 2'b01, 32'h20, 0, 0, 0, 0); #2;
    checkOutput("alias_same_cycle_old", 32'(PredTaken), 32'd1);
    checkOutput("alias_same_cycle_old_tgt", PredTarget, 32'h60);
    tick();
    idle(); #2;
    checkOutput("alias_evicted_miss", 32'(PredTaken), 32'd0);
    checkOutput("alias_evicted_target", PredTarget, 32'h44);
    IfPC = 9'h140; #1;
    checkOutput("alias_new_target", PredTarget, 32'h160);
    tick();

    // Stale alias on a non-control instruction
    applyStimulus(1, 9'h140, 0, 0, 2'b00, 0, 0, 0, 1, 32'h160); tick();
    idle(); #2;
    checkOutput("stale_redirect_pc", RedirectPC, 32'h144);
    checkOutput("stale_invalidated", 32'(PredTaken), 32'd0);
    tick();

    // ExValid low ignores everything else
    applyStimulus(0, 9'h1FC, 1, 1, 2'b01, 32'h40, 0, 1, 0, 0); #2;
    checkOutput("pc_plus4_unwrapped", ExPCPlus4, 32'h200);
    tick();
    idle(); #2;
    checkOutput("invalid_no_redirect", 32'(Redirect), 32'd0);
    tick();

    // Reset in the redirect cycle, then counter saturation
    IfPC = 9'h040; reset = 1;
    applyStimulus(1, 9'h040, 0, 1, 2'b01, 32'h20, 0, 0, 0, 0); tick();
    reset = 0; idle(); #2;
    checkOutput("rst_redirect_dropped", 32'(Redirect), 32'd0);
    checkOutput("rst_btb_empty", 32'(PredTaken), 32'd0);
    checkOutput("rst_mispred_count", 32'(MispredCount), 32'd0);
    tick();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 9'h040, 0, 1, 2'b01, 32'h20, 0, 0, 0, 0); tick();
    end
    idle(); #2;
    checkOutput("sat_mispred_count", 32'(MispredCount), 32'd15);
    checkOutput("sat_branch_count", 32'(BranchCount), 32'd15);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
